// File: rtl/nes_pad_reader.sv
// NES controller poller: latches the pad, clocks out 8 serial bits and publishes an active-high button vector.
// Optional macro NES_PAD_EDGE_EN adds pressed_out, the set of buttons newly pressed since the previous frame.
`timescale 1ns/1ps

module nes_pad_reader #(
    parameter int HALF_PER    = 195,
    parameter int POLL_PERIOD = 1083333
) (
    input  logic       vclk_in,
    input  logic       rst_n_in,
    input  logic       nes_data_in,
    output logic       nes_latch_out,
    output logic       nes_clk_out,
    output logic [7:0] buttons_out,
    output logic       valid_out
`ifdef NES_PAD_EDGE_EN
    ,
    output logic [7:0] pressed_out
`endif
);

    localparam int PW = $clog2(POLL_PERIOD);
    localparam int CW = $clog2(2 * HALF_PER);
    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_PERIOD - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF_PER - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_PER - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LATCH    = 3'd1,
        BIT_LOW  = 3'd2,
        BIT_HIGH = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t          state;
    logic [PW-1:0]   poll_cnt;
    logic [CW-1:0]   phase_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;
    logic            sync1;
    logic            sync2;

    // Idle level of the pad data line is high, so the synchronizer resets to 1.
    always_ff @(posedge vclk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= nes_data_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge vclk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            poll_cnt <= '0;
        end else if (poll_cnt == POLL_LAST) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    always_ff @(posedge vclk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= IDLE;
            phase_cnt     <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            nes_latch_out <= 1'b0;
            nes_clk_out   <= 1'b0;
            buttons_out   <= '0;
            valid_out     <= 1'b0;
`ifdef NES_PAD_EDGE_EN
            pressed_out   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // A poll tick is only honoured here; ticks during a frame are dropped.
                    if (poll_cnt == '0) begin
                        state         <= LATCH;
                        phase_cnt     <= '0;
                        nes_latch_out <= 1'b1;
                    end
                end
                LATCH: begin
                    if (phase_cnt == LATCH_LAST) begin
                        state         <= BIT_LOW;
                        phase_cnt     <= '0;
                        bit_idx       <= '0;
                        nes_latch_out <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                BIT_LOW: begin
                    if (phase_cnt == HALF_LAST) begin
                        // Sample just before the rising edge that makes the pad shift.
                        shift_reg[bit_idx] <= ~sync2;
                        state              <= BIT_HIGH;
                        phase_cnt          <= '0;
                        nes_clk_out        <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                BIT_HIGH: begin
                    if (phase_cnt == HALF_LAST) begin
                        phase_cnt   <= '0;
                        nes_clk_out <= 1'b0;
                        if (bit_idx == 3'd7) begin
                            state       <= DONE;
                            buttons_out <= shift_reg;
                            valid_out   <= 1'b1;
`ifdef NES_PAD_EDGE_EN
                            pressed_out <= shift_reg & ~buttons_out;
`endif
                        end else begin
                            state   <= BIT_LOW;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    valid_out <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    phase_cnt     <= '0;
                    nes_latch_out <= 1'b0;
                    nes_clk_out   <= 1'b0;
                    valid_out     <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // A frame plus the return to IDLE must fit inside one poll period.
    a_params: assert property (@(posedge vclk_in)
        (POLL_PERIOD >= 18 * HALF_PER + 2) && (HALF_PER >= 4));
`endif

endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed bench for nes_pad_reader with HALF_PER=4, POLL_PERIOD=100 and a behavioural pad model.
`timescale 1ns/1ps

module tb_nes_pad_reader;

    logic       vclk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       nes_data_in;
    logic       nes_latch_out;
    logic       nes_clk_out;
    logic [7:0] buttons_out;
    logic       valid_out;
`ifdef NES_PAD_EDGE_EN
    logic [7:0] pressed_out;
`endif

    int total = 0;
    int bad   = 0;

    // pad model: parallel load on latch, shift on rising pad clock, line idles high
    logic [7:0] pad_pressed = 8'h00;
    int         pad_idx = 8;
    logic       pad_mode = 1'b1;
    logic       manual_data = 1'b1;
    logic       pad_line;

    always #5 vclk_in = ~vclk_in;

    nes_pad_reader #(.HALF_PER(4), .POLL_PERIOD(100)) dut (
        .vclk_in       (vclk_in),
        .rst_n_in      (rst_n_in),
        .nes_data_in   (nes_data_in),
        .nes_latch_out (nes_latch_out),
        .nes_clk_out   (nes_clk_out),
        .buttons_out   (buttons_out),
        .valid_out     (valid_out)
`ifdef NES_PAD_EDGE_EN
        ,
        .pressed_out   (pressed_out)
`endif
    );

    always @(posedge nes_clk_out or posedge nes_latch_out) begin
        if (nes_latch_out) pad_idx <= 0;
        else               pad_idx <= pad_idx + 1;
    end

    assign pad_line    = (pad_idx < 8) ? ~pad_pressed[pad_idx[2:0]] : 1'b1;
    assign nes_data_in = pad_mode ? pad_line : manual_data;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // {latch, clk, valid} expected k edges after reset release (edge 0 starts the first frame)
    function automatic logic [2:0] exp_seq(input int k);
        int   kk;
        logic l, c, v;
        kk = k % 100;
        l  = (kk < 8);
        c  = (kk >= 8) && (kk < 72) && (((kk - 8) % 8) >= 4);
        v  = (kk == 72);
        return {l, c, v};
    endfunction

    task automatic tick(input int k);
        @(posedge vclk_in);
        #1;
        check("seq", {13'd0, nes_latch_out, nes_clk_out, valid_out}, {13'd0, exp_seq(k)});
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge vclk_in);
        check("rst_latch",   {15'd0, nes_latch_out}, 16'd0);
        check("rst_clk",     {15'd0, nes_clk_out},   16'd0);
        check("rst_buttons", {8'd0, buttons_out},    16'd0);
        check("rst_valid",   {15'd0, valid_out},     16'd0);

        // pad frame 81, unplugged frame 00, pad frame 81, then reset mid-frame
        pad_mode    = 1'b1;
        pad_pressed = 8'h81;
        rst_n_in    = 1'b1;
        for (int k = 0; k < 346; k++) begin
            tick(k);
            if (k == 71)  check("hold_before_f0", {8'd0, buttons_out}, 16'h0000);
            if (k == 72)  check("frame0_81",      {8'd0, buttons_out}, 16'h0081);
            if (k == 80)  begin pad_mode = 1'b0; manual_data = 1'b1; end
            if (k == 171) check("hold_before_f1", {8'd0, buttons_out}, 16'h0081);
            if (k == 172) check("unplugged_00",   {8'd0, buttons_out}, 16'h0000);
            if (k == 180) begin pad_mode = 1'b1; pad_pressed = 8'h81; end
            if (k == 272) check("frame2_81",      {8'd0, buttons_out}, 16'h0081);
            if (k == 300) pad_pressed = 8'h3C;
        end

        // edge 345 is inside the 5th clk-high phase; reset must act before the next edge
        check("mid_clk_high", {15'd0, nes_clk_out}, 16'd1);
        #2 rst_n_in = 1'b0;
        #1;
        check("async_latch",   {15'd0, nes_latch_out}, 16'd0);
        check("async_clk",     {15'd0, nes_clk_out},   16'd0);
        check("async_buttons", {8'd0, buttons_out},    16'd0);
        check("async_valid",   {15'd0, valid_out},     16'd0);
        repeat (3) @(negedge vclk_in);
        check("held_rst_buttons", {8'd0, buttons_out}, 16'd0);

        // Up, Up+A, none, then synchronizer latency frame
        pad_mode    = 1'b1;
        pad_pressed = 8'h10;
        rst_n_in    = 1'b1;
        for (int k = 0; k < 380; k++) begin
            tick(k);
            if (k == 72) begin
                check("up_10", {8'd0, buttons_out}, 16'h0010);
`ifdef NES_PAD_EDGE_EN
                check("press_10", {8'd0, pressed_out}, 16'h0010);
`endif
            end
            if (k == 80)  pad_pressed = 8'h11;
            if (k == 99)  check("hold_between", {8'd0, buttons_out}, 16'h0010);
            if (k == 172) begin
                check("upa_11", {8'd0, buttons_out}, 16'h0011);
`ifdef NES_PAD_EDGE_EN
                check("press_01", {8'd0, pressed_out}, 16'h0001);
`endif
            end
            if (k == 180) pad_pressed = 8'h00;
            if (k == 272) begin
                check("none_00", {8'd0, buttons_out}, 16'h0000);
`ifdef NES_PAD_EDGE_EN
                check("press_00", {8'd0, pressed_out}, 16'h0000);
`endif
            end
            if (k == 280) begin pad_mode = 1'b0; manual_data = 1'b1; end
            // bit0 samples at edge 312: change 1 cycle before -> old (released) value
            if (k == 311) manual_data = 1'b0;
            if (k == 313) manual_data = 1'b1;
            // bit1 samples at edge 320: change 3 cycles before -> new (pressed) value
            if (k == 317) manual_data = 1'b0;
            if (k == 320) manual_data = 1'b1;
            if (k == 372) begin
                check("sync_latency_02", {8'd0, buttons_out}, 16'h0002);
`ifdef NES_PAD_EDGE_EN
                check("press_02", {8'd0, pressed_out}, 16'h0002);
`endif
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
